// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// default geometry, controller state encoding and address field helpers.
package dcache_pkg;

    localparam int DEF_INDEX_BITS = 4;
    localparam int DEF_WOFF_BITS  = 2;
    localparam int DEF_TAG_BITS   = 32 - 2 - DEF_WOFF_BITS - DEF_INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_WDONE  = 2'd3
    } state_t;

    // Word offset inside a line; the two byte-select bits are dropped.
    function automatic logic [31:0] addrOffset(input logic [31:0] addr,
                                               input int woffBits);
        return (addr >> 2) & ((32'd1 << woffBits) - 32'd1);
    endfunction

    // Line index, sitting just above the word offset.
    function automatic logic [31:0] addrIndex(input logic [31:0] addr,
                                              input int woffBits,
                                              input int indexBits);
        return (addr >> (2 + woffBits)) & ((32'd1 << indexBits) - 32'd1);
    endfunction

    // Tag is everything above the index.
    function automatic logic [31:0] addrTag(input logic [31:0] addr,
                                            input int woffBits,
                                            input int indexBits);
        return addr >> (2 + woffBits + indexBits);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid, tag and data storage for the data cache. One combinational read
// port addressed by (index, offset) and one synchronous write port that can
// write a single data word and/or set the tag and valid bit of a line.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WOFF_BITS  = DEF_WOFF_BITS,
    parameter int TAG_BITS   = 32 - 2 - WOFF_BITS - INDEX_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [INDEX_BITS-1:0] i_rdIndex,
    input  logic [WOFF_BITS-1:0]  i_rdOffset,
    output logic                  o_rdValid,
    output logic [TAG_BITS-1:0]   o_rdTag,
    output logic [31:0]           o_rdWord,
    input  logic                  i_wordWe,
    input  logic [INDEX_BITS-1:0] i_wordIndex,
    input  logic [WOFF_BITS-1:0]  i_wordOffset,
    input  logic [31:0]           i_wordData,
    input  logic                  i_lineWe,
    input  logic [INDEX_BITS-1:0] i_lineIndex,
    input  logic [TAG_BITS-1:0]   i_lineTag,
    input  logic                  i_lineValid
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << WOFF_BITS;

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [0:LINES-1];
    logic [31:0]         r_data [0:LINES*WORDS-1];

    // Valid bits are the only storage that must come out of reset cleared.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
        end else if (i_lineWe) begin
            r_valid[i_lineIndex] <= i_lineValid;
        end
    end

    // Tags are written together with the valid bit; contents are don't-care while invalid.
    always_ff @(posedge i_clk) begin
        if (i_lineWe) begin
            r_tag[i_lineIndex] <= i_lineTag;
        end
    end

    // Single-word data write, used by store hits and by each refill beat.
    always_ff @(posedge i_clk) begin
        if (i_wordWe) begin
            r_data[{i_wordIndex, i_wordOffset}] <= i_wordData;
        end
    end

    assign o_rdValid = r_valid[i_rdIndex];
    assign o_rdTag   = r_tag[i_rdIndex];
    assign o_rdWord  = r_data[{i_rdIndex, i_rdOffset}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read misses refill a whole line word by word over a req/ack memory port;
// every store goes straight to memory and also updates the line on a hit.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WOFF_BITS  = DEF_WOFF_BITS
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
);

    localparam int TAG_BITS = 32 - 2 - WOFF_BITS - INDEX_BITS;
    localparam int WORDS    = 1 << WOFF_BITS;
    localparam logic [WOFF_BITS-1:0] LAST_WORD = WOFF_BITS'(WORDS - 1);

    logic [WOFF_BITS-1:0]  w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_rdValid;
    logic [TAG_BITS-1:0]   w_rdTag;
    logic [31:0]           w_rdWord;
    logic                  w_hit;
    logic                  w_isWrite;
    logic                  w_isRead;

    logic                  w_wordWe;
    logic [INDEX_BITS-1:0] w_wordIndex;
    logic [WOFF_BITS-1:0]  w_wordOffset;
    logic [31:0]           w_wordData;
    logic                  w_lineWe;
    logic [INDEX_BITS-1:0] w_lineIndex;
    logic [TAG_BITS-1:0]   w_lineTag;
    logic                  w_lineValid;
    logic                  w_stall;

    state_t                r_state;
    logic [TAG_BITS-1:0]   r_tag;
    logic [INDEX_BITS-1:0] r_index;
    logic [WOFF_BITS-1:0]  r_cnt;
    logic                  r_memReq;
    logic                  r_memWe;
    logic [31:0]           r_wAddr;
    logic [31:0]           r_wData;
    logic [31:0]           r_hitCount;
    logic [31:0]           r_missCount;
    logic                  r_refillDone;

    assign w_offset = WOFF_BITS'(addrOffset(i_addr, WOFF_BITS));
    assign w_index  = INDEX_BITS'(addrIndex(i_addr, WOFF_BITS, INDEX_BITS));
    assign w_tag    = TAG_BITS'(addrTag(i_addr, WOFF_BITS, INDEX_BITS));

    // A store wins when both request lines are raised together.
    assign w_isWrite = i_mem_write;
    assign w_isRead  = i_mem_read & ~i_mem_write;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .WOFF_BITS  (WOFF_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rdIndex    (w_index),
        .i_rdOffset   (w_offset),
        .o_rdValid    (w_rdValid),
        .o_rdTag      (w_rdTag),
        .o_rdWord     (w_rdWord),
        .i_wordWe     (w_wordWe),
        .i_wordIndex  (w_wordIndex),
        .i_wordOffset (w_wordOffset),
        .i_wordData   (w_wordData),
        .i_lineWe     (w_lineWe),
        .i_lineIndex  (w_lineIndex),
        .i_lineTag    (w_lineTag),
        .i_lineValid  (w_lineValid)
    );

    assign w_hit = w_rdValid & (w_rdTag == w_tag);

    // Array write steering: store hits in IDLE, the victim invalidate on a
    // read miss, and one word per ack while refilling (tag+valid on the last).
    always_comb begin
        w_wordWe     = 1'b0;
        w_wordIndex  = w_index;
        w_wordOffset = w_offset;
        w_wordData   = i_write_data;
        w_lineWe     = 1'b0;
        w_lineIndex  = w_index;
        w_lineTag    = w_tag;
        w_lineValid  = 1'b0;
        if (!i_reset) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_isWrite && w_hit) begin
                        w_wordWe = 1'b1;
                    end else if (w_isRead && !w_hit) begin
                        w_lineWe    = 1'b1;
                        w_lineValid = 1'b0;
                    end
                end
                ST_REFILL: begin
                    if (i_mem_ack) begin
                        w_wordWe     = 1'b1;
                        w_wordIndex  = r_index;
                        w_wordOffset = r_cnt;
                        w_wordData   = i_mem_rdata;
                        if (r_cnt == LAST_WORD) begin
                            w_lineWe    = 1'b1;
                            w_lineIndex = r_index;
                            w_lineTag   = r_tag;
                            w_lineValid = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pipeline hold: misses and stores stall in IDLE, the memory phases always
    // stall, and WDONE gives the store its single retiring cycle.
    always_comb begin
        w_stall = 1'b0;
        unique case (r_state)
            ST_IDLE:   w_stall = w_isWrite | (w_isRead & ~w_hit);
            ST_REFILL: w_stall = 1'b1;
            ST_WRITE:  w_stall = 1'b1;
            ST_WDONE:  w_stall = 1'b0;
            default:   w_stall = 1'b0;
        endcase
    end

    // Controller FSM with registered memory request, latches and counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_hitCount   <= '0;
            r_missCount  <= '0;
            r_refillDone <= 1'b0;
        end else begin
            r_refillDone <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_isWrite) begin
                        r_wAddr  <= {i_addr[31:2], 2'b00};
                        r_wData  <= i_write_data;
                        r_memReq <= 1'b1;
                        r_memWe  <= 1'b1;
                        r_state  <= ST_WRITE;
                    end else if (i_mem_read) begin
                        if (w_hit) begin
                            if (!r_refillDone) begin
                                r_hitCount <= r_hitCount + 32'd1;
                            end
                        end else begin
                            r_tag       <= w_tag;
                            r_index     <= w_index;
                            r_cnt       <= '0;
                            r_missCount <= r_missCount + 32'd1;
                            r_memReq    <= 1'b1;
                            r_memWe     <= 1'b0;
                            r_state     <= ST_REFILL;
                        end
                    end
                end
                ST_REFILL: begin
                    if (i_mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            r_memReq     <= 1'b0;
                            r_refillDone <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_mem_ack) begin
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_state  <= ST_WDONE;
                    end
                end
                ST_WDONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stall      = w_stall & ~i_reset;
    assign o_mem_req    = r_memReq & ~i_reset;
    assign o_mem_we     = r_memWe & ~i_reset;
    assign o_mem_addr   = r_memWe ? r_wAddr : {r_tag, r_index, r_cnt, 2'b00};
    assign o_mem_wdata  = r_wData;
    assign o_read_data  = (i_mem_read && w_hit) ? w_rdWord : 32'd0;
    assign o_hit_count  = r_hitCount;
    assign o_miss_count = r_missCount;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores, compared against a transaction-level cache/memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = 32'd0;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    int total = 0;
    int bad = 0;
    int latency = 3;
    int waitCnt = 0;

    logic [31:0] envMem [logic [31:0]];
    logic [31:0] refMem [logic [31:0]];
    bit          refValid [16];
    logic [23:0] refTag [16];
    int unsigned refHits = 0;
    int unsigned refMisses = 0;

    bit          logWe [$];
    logic [31:0] logAddr [$];
    logic [31:0] logData [$];

    dcache_ctrl dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_mem_read   (memRead),
        .i_mem_write  (memWrite),
        .i_addr       (addr),
        .i_write_data (writeData),
        .o_read_data  (readData),
        .o_stall      (stall),
        .o_mem_req    (memReq),
        .o_mem_we     (memWe),
        .o_mem_addr   (memAddr),
        .o_mem_wdata  (memWdata),
        .i_mem_ack    (memAck),
        .i_mem_rdata  (memRdata),
        .o_hit_count  (hitCount),
        .o_miss_count (missCount)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] envRead(input logic [31:0] a);
        return envMem.exists(a) ? envMem[a] : initWord(a);
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    // Main memory: acks each word after 'latency' wait cycles and logs it.
    always @(negedge clk) begin
        #1;
        if (reset || !memReq) begin
            memAck  = 1'b0;
            waitCnt = 0;
        end else if (waitCnt >= latency) begin
            memAck  = 1'b1;
            waitCnt = 0;
            logWe.push_back(memWe);
            logAddr.push_back(memAddr);
            logData.push_back(memWdata);
            if (memWe) begin
                envMem[memAddr] = memWdata;
                memRdata = 32'd0;
            end else begin
                memRdata = envRead(memAddr);
            end
        end else begin
            memAck  = 1'b0;
            waitCnt = waitCnt + 1;
        end
    end

    // Global time bound in case the design never releases the pipeline.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time bound exceeded");
    end

    task automatic applyStimulus(input bit rd, input bit wr,
                                 input logic [31:0] a, input logic [31:0] d);
        memRead   = rd;
        memWrite  = wr;
        addr      = a;
        writeData = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) begin
            refValid[i] = 1'b0;
            refTag[i]   = '0;
        end
        refHits   = 0;
        refMisses = 0;
    endtask

    // One complete request: predict from the model, hold until the pipeline
    // is released, then compare timing, data, counters and memory traffic.
    task automatic doAccess(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input int lat);
        logic [31:0] wordAddr;
        logic [31:0] base;
        logic [31:0] expData;
        int          expStall;
        int          cycles;
        int          idx;
        logic [23:0] tg;
        bit          hit;
        bit          expWe [$];
        logic [31:0] expAddr [$];
        logic [31:0] expWdata [$];

        @(negedge clk);
        latency = lat;
        logWe.delete();
        logAddr.delete();
        logData.delete();
        applyStimulus(rd, wr, a, d);

        wordAddr = {a[31:2], 2'b00};
        base     = {a[31:4], 4'b0000};
        idx      = int'(a[7:4]);
        tg       = a[31:8];
        expData  = 32'd0;
        expStall = 0;
        if (wr) begin
            expStall = 2 + lat;
            expWe.push_back(1'b1);
            expAddr.push_back(wordAddr);
            expWdata.push_back(d);
            refMem[wordAddr] = d;
        end else if (rd) begin
            hit     = refValid[idx] && (refTag[idx] == tg);
            expData = refRead(wordAddr);
            if (hit) begin
                refHits++;
            end else begin
                expStall = 1 + 4 * (lat + 1);
                refMisses++;
                refValid[idx] = 1'b1;
                refTag[idx]   = tg;
                for (int w = 0; w < 4; w++) begin
                    expWe.push_back(1'b0);
                    expAddr.push_back(base + 32'(4 * w));
                    expWdata.push_back(32'd0);
                end
            end
        end

        #2;
        cycles = 0;
        while (stall === 1'b1 && cycles < 400) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        checkOutput("stall_cycles", 32'(cycles), 32'(expStall));
        checkOutput("req_low_at_retire", 32'(memReq), 32'd0);
        if (rd && !wr) begin
            checkOutput("read_data", readData, expData);
        end

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, a, d);
        #2;
        checkOutput("idle_stall", 32'(stall), 32'd0);
        checkOutput("idle_req", 32'(memReq), 32'd0);
        checkOutput("hit_count", hitCount, 32'(refHits));
        checkOutput("miss_count", missCount, 32'(refMisses));
        checkOutput("mem_txn_count", 32'(logAddr.size()), 32'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < logAddr.size(); i++) begin
            checkOutput("mem_txn_addr", logAddr[i], expAddr[i]);
            checkOutput("mem_txn_we", 32'(logWe[i]), 32'(expWe[i]));
            if (expWe[i]) begin
                checkOutput("mem_txn_wdata", logData[i], expWdata[i]);
            end
        end
    endtask

    // Directed scenarios then random traffic.
    initial begin
        int cycles;
        int op;
        logic [31:0] ra;
        logic [31:0] tagPick [3];

        tagPick[0] = 32'h0000_0000;
        tagPick[1] = 32'h0000_0004;
        tagPick[2] = 32'h0001_2345;

        clearModel();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_req", 32'(memReq), 32'd0);
        checkOutput("reset_we", 32'(memWe), 32'd0);
        checkOutput("reset_hits", hitCount, 32'd0);
        checkOutput("reset_misses", missCount, 32'd0);
        reset = 1'b0;

        $display("[TB] directed: miss, hit, store hit, store miss");
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3);
        doAccess(1'b1, 1'b0, 32'h0000_0044, 32'd0, 3);
        doAccess(1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF, 3);
        doAccess(1'b1, 1'b0, 32'h0000_0048, 32'd0, 3);
        doAccess(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 3);
        doAccess(1'b1, 1'b0, 32'h0000_1000, 32'd0, 3);

        $display("[TB] directed: conflict eviction");
        doAccess(1'b1, 1'b0, 32'h0000_0440, 32'd0, 3);
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3);

        $display("[TB] directed: reset during refill");
        @(negedge clk);
        latency = 3;
        logWe.delete();
        logAddr.delete();
        logData.delete();
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, 32'd0);
        #2;
        cycles = 0;
        while (logAddr.size() < 2 && cycles < 200) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        checkOutput("refill_two_acks", 32'(logAddr.size()), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        checkOutput("midreset_stall", 32'(stall), 32'd0);
        checkOutput("midreset_req", 32'(memReq), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("postreset_req", 32'(memReq), 32'd0);
        checkOutput("postreset_hits", hitCount, 32'd0);
        checkOutput("postreset_misses", missCount, 32'd0);
        clearModel();
        reset = 1'b0;
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'd0, 3);
        doAccess(1'b1, 1'b0, 32'h0000_0080, 32'd0, 3);

        $display("[TB] directed: zero-latency memory");
        doAccess(1'b1, 1'b0, 32'h0000_00C0, 32'd0, 0);
        doAccess(1'b0, 1'b1, 32'h0000_00C4, 32'hCAFE_F00D, 0);
        doAccess(1'b1, 1'b0, 32'h0000_00C4, 32'd0, 0);
        doAccess(1'b1, 1'b1, 32'h0000_00C8, 32'h0BAD_CAFE, 1);
        doAccess(1'b1, 1'b0, 32'h0000_00C8, 32'd0, 2);

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            ra = (tagPick[$urandom_range(0, 2)] << 8)
               | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                doAccess(1'b1, 1'b0, ra, 32'd0, int'($urandom_range(0, 3)));
            end else if (op <= 8) begin
                doAccess(1'b0, 1'b1, ra, $urandom, int'($urandom_range(0, 3)));
            end else begin
                doAccess(1'b1, 1'b1, ra, $urandom, int'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache sitting between the pipeline's memory stage and a word-wide main-memory port. It accepts the M-stage request (mem_read / mem_write, address, write data) and returns read data. It raises stall for as long as the pipeline must hold. Misses are serviced by multi-word line refills over a req/ack handshake to main memory.

Parameters:
INDEX_BITS, 4, line index width (2^INDEX_BITS lines)
WOFF_BITS, 2, word-offset width (2^WOFF_BITS words per line)
TAG_BITS, 32-2-WOFF_BITS-INDEX_BITS = 24, tag width (derived localparam)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
mem_read  in  1  load request from M stage
mem_write  in  1  store request from M stage
addr  in  32  byte address; addr[1:0] ignored
write_data  in  32  store data
read_data  out  32  load data; valid when mem_read & ~stall
stall  out  1  pipeline hold, combinational
mem_req  out  1  main-memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  memory write data
mem_ack  in  1  memory completes current word; may arrive in the same cycle as mem_req
mem_rdata  in  32  read word, valid with mem_ack
hit_count  out  32  completed read hits
miss_count  out  32  read misses (refills started)

Behaviour:
- Address split: offset = addr[WOFF_BITS+1:2]; index = next INDEX_BITS; tag = remaining upper bits.
- hit = valid[index] & (tag_arr[index] == tag). Evaluated combinationally.
- States: IDLE, REFILL, WRITE, WDONE.
- If mem_read and mem_write are both high, the request is treated as a write.
- IDLE:
  - Read hit: read_data = line word, stall = 0, hit_count++.
  - Read miss: stall = 1, latch line base {tag,index,0}, clear word counter, miss_count++, go to REFILL.
  - Write: stall = 1. On a hit, update the cached word at this edge; on a miss, leave the cache unchanged. Latch addr/data and go to WRITE.
  - No request: stall = 0.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = base + 4*cnt, stall = 1.
  - Each mem_ack writes mem_rdata to data[index][cnt] and increments cnt.
  - On the ack for the last word: set tag and valid, go to IDLE. The still-held read now hits, so stall drops the cycle after the final ack.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_addr / mem_wdata from latches, stall = 1.
  - On mem_ack, go to WDONE.
- WDONE:
  - stall = 0 for exactly one cycle so the store retires; mem_req = 0; go to IDLE.
  - A back-to-back store is seen in IDLE on the next cycle.
- mem_addr and mem_wdata are stable while mem_req is high. mem_req drops the cycle after the final ack.
- read_data = 0 when not (mem_read & hit).
- Counters wrap modulo 2^32.
- Reset:
  - Clears all valid bits, counters and cnt; state goes to IDLE.
  - mem_req = 0, mem_we = 0, stall = 0 while reset is high.
  - Reset mid-REFILL or mid-WRITE abandons the transaction; the partial line stays invalid. Tag/data arrays need no reset.

Decomposition:
- Package dcache_pkg: state encoding, INDEX_BITS / WOFF_BITS / TAG_BITS defaults, address field slice helpers.
- Sub-module dcache_array: valid, tag and data storage. It has a combinational read port (index, offset) and one synchronous write port (word write plus line tag/valid set). The valid clear on reset lives inside it.

Test Plan:
- Memory model with 3-cycle ack latency. After reset, read 0x40 → stall = 1; memory reads at 0x40, 0x44, 0x48, 0x4C; stall = 0 one cycle after the 4th ack; read_data = mem[0x40]; miss_count = 1.
- Then read 0x44 → stall = 0 same cycle, read_data = mem[0x44], hit_count = 1, no mem_req.
- Write 0x48 = 0xDEADBEEF (hit) → a single mem_req with mem_we = 1 at 0x48; stall high until ack, then 1 low cycle. A following read of 0x48 hits and returns 0xDEADBEEF.
- Write miss 0x1000 = 0x12345678 → memory written, no refill. A following read of 0x1000 misses and refills 0x1000–0x100C, returning 0x12345678.
- Conflict: read 0x440 after 0x40 is cached (same index 4) → refill evicts the line. A subsequent read of 0x40 misses; miss_count increments.
- Assert reset after the 2nd ack of a refill → next cycle mem_req = 0, stall = 0, counters 0. A re-read of 0x40 misses and refills all 4 words.
- Ack in the same cycle as the request (0-latency memory) → refill completes in 4 cycles; a write completes in WRITE + WDONE = 2 cycles.
